fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction ROM address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter ROM_LATENCY, default 1, legal 1..3, SHALL set the cycles from address presentation to valid RomQ.
REQ-004 Clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 ProcessorReset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 ProcessorEnable  in  1  SHALL be the run switch, level-sensitive.
REQ-007 Step  in  1  SHALL be a single-step request, one-cycle pulse, already synchronised.
REQ-008 RomQ  in  DATA_W  SHALL be the ROM read data.
REQ-009 ExecDone  in  1  SHALL indicate that the datapath has finished the current instruction.
REQ-010 Halt  in  1  SHALL indicate a halt instruction; sampled only with ExecDone.
REQ-011 LoadPC  in  1  SHALL request a branch; sampled only with ExecDone.
REQ-012 PCIn  in  ADDR_W  SHALL be the branch target.
REQ-013 RomAddress  out  ADDR_W  SHALL be the ROM address (MuxMA).
REQ-014 RomClken  out  1  SHALL be the ROM clock enable (MEM_Read).
REQ-015 IR  out  DATA_W  SHALL be the instruction register.
REQ-016 ExecStart  out  1  SHALL be a one-cycle pulse that starts datapath execution.
REQ-017 TimeStep  out  3  SHALL encode the state: IDLE=0, FETCH=1, WAIT=2, LATCH=3, EXEC=4, HALTED=7.
REQ-018 OperationFinished  out  1  SHALL be high only in HALTED.
REQ-019 PC  out  ADDR_W  SHALL be the program counter, for hex display.
REQ-020 InstrCount  out  16  SHALL count retired instructions, for hex display.

Function
REQ-021 IDLE SHALL go to FETCH when ProcessorEnable=1, subject to REQ-035; otherwise it SHALL stay in IDLE.
REQ-022 FETCH SHALL last 1 cycle and drive RomAddress=PC and RomClken=1, then go to WAIT.
REQ-023 WAIT SHALL last exactly ROM_LATENCY cycles with RomClken=1 and RomAddress held, then go to LATCH.
REQ-024 LATCH SHALL last 1 cycle: IR<=RomQ and PC<=PC+1 modulo 2^ADDR_W at its closing edge; then go to EXEC.
REQ-025 ExecStart SHALL be high in the first EXEC cycle only.
REQ-026 RomClken SHALL be 0 in IDLE, LATCH, EXEC and HALTED.
REQ-027 In EXEC, the block SHALL wait indefinitely for ExecDone; ExecDone in the ExecStart cycle SHALL be honoured.
REQ-028 On ExecDone with LoadPC=1, PC<=PCIn SHALL occur and override the LATCH increment.
REQ-029 On ExecDone with Halt=1, the block SHALL go to HALTED; Halt SHALL win over LoadPC, and PC SHALL keep its incremented value.
REQ-030 On ExecDone with Halt=0, the block SHALL go to FETCH if ProcessorEnable=1 (and not in step mode), else to IDLE.
REQ-031 On ExecDone, InstrCount SHALL increment and saturate at 16'hFFFF, with Halt counting as retired.
REQ-032 Deasserting ProcessorEnable mid-instruction SHALL NOT abort it; the sequence SHALL complete to IDLE.
REQ-033 HALTED SHALL be left only by ProcessorReset; Step and ProcessorEnable SHALL be ignored there.

Reset
REQ-034 On ProcessorReset, the block SHALL immediately set state=IDLE, PC=0, IR=0, InstrCount=0, RomAddress=0, RomClken=0, ExecStart=0 and OperationFinished=0; assertion mid-WAIT SHALL discard the in-flight fetch.

Configuration
REQ-035 When SINGLE_STEP_EN is defined, leaving IDLE SHALL require ProcessorEnable=1 AND a Step pulse, and EXEC SHALL always return to IDLE; when it is undefined, Step SHALL be ignored and the block SHALL free-run per REQ-021/030.

Structure
REQ-036 The state encoding (REQ-017) and ROM_LATENCY legal bounds SHALL live in the shared package processor_pkg.
REQ-037 The latency counter and PC/InstrCount registers SHALL stay inline; no sub-module is required.

Verification
REQ-038 Reset, enable=1, ROM[0]=32'h11223344, ExecDone 2 cycles after ExecStart -> TimeStep 1,2,3,4,4,4 then 1; IR=32'h11223344; PC=1; InstrCount=1.
REQ-039 ROM_LATENCY=3 -> WAIT held for exactly 3 cycles with RomClken=1; IR latches the correct word.
REQ-040 ExecDone with LoadPC=1, PCIn=8'h40 -> next FETCH drives RomAddress=8'h40; PC=8'hFF on increment -> wraps to 8'h00.
REQ-041 ExecDone with Halt=1 and LoadPC=1 -> HALTED, OperationFinished=1, PC not loaded; later Step/enable -> no change until reset.
REQ-042 ProcessorReset pulsed during WAIT -> all outputs zero asynchronously; no IR update; restart fetches address 0.
REQ-043 With SINGLE_STEP_EN defined, enable=1 and no Step -> stays in IDLE; 3 Step pulses -> InstrCount=3, returning to IDLE after each.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared sequencer definitions: TimeStep state encoding and ROM latency bounds.
package processor_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_LATCH  = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd7;

    localparam int ROM_LAT_MIN   = 1;
    localparam int ROM_LAT_MAX   = 3;
    localparam int ROM_LAT_CNT_W = 2;

    // The ROM is addressed and clocked only while a fetch is in flight.
    function automatic logic rom_active(input logic [2:0] state);
        return (state == ST_FETCH) || (state == ST_WAIT);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: IDLE -> FETCH -> WAIT -> LATCH -> EXEC -> FETCH/IDLE/HALTED.
// Define SINGLE_STEP_EN to require a Step pulse for every instruction.
module fetch_sequencer
    import processor_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic              Clock,
    input  logic              ProcessorReset,
    input  logic              ProcessorEnable,
    input  logic              Step,
    input  logic [DATA_W-1:0] RomQ,
    input  logic              ExecDone,
    input  logic              Halt,
    input  logic              LoadPC,
    input  logic [ADDR_W-1:0] PCIn,
    output logic [ADDR_W-1:0] RomAddress,
    output logic              RomClken,
    output logic [DATA_W-1:0] IR,
    output logic              ExecStart,
    output logic [2:0]        TimeStep,
    output logic              OperationFinished,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount
);

    if (ROM_LATENCY < ROM_LAT_MIN || ROM_LATENCY > ROM_LAT_MAX) begin : g_bad_latency
        $error("fetch_sequencer: ROM_LATENCY out of range");
    end

    logic [2:0]               r_state;
    logic [ADDR_W-1:0]        r_pc;
    logic [DATA_W-1:0]        r_ir;
    logic [15:0]              r_count;
    logic [ROM_LAT_CNT_W-1:0] r_wait_cnt;
    logic                     r_exec_first;

    logic w_start;
    logic w_continue;

`ifdef SINGLE_STEP_EN
    assign w_start    = ProcessorEnable & Step;
    assign w_continue = 1'b0;
`else
    logic w_unused_step;
    assign w_unused_step = Step;
    assign w_start       = ProcessorEnable;
    assign w_continue    = ProcessorEnable;
`endif

    always_ff @(posedge Clock or posedge ProcessorReset) begin
        if (ProcessorReset) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_count      <= '0;
            r_wait_cnt   <= '0;
            r_exec_first <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_wait_cnt <= ROM_LAT_CNT_W'(ROM_LATENCY - 1);
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) r_state <= ST_LATCH;
                    else                  r_wait_cnt <= r_wait_cnt - 1'b1;
                end
                ST_LATCH: begin
                    r_ir         <= RomQ;
                    r_pc         <= r_pc + 1'b1;
                    r_exec_first <= 1'b1;
                    r_state      <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_exec_first <= 1'b0;
                    if (ExecDone) begin
                        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
                        // Halt wins over a simultaneous branch; PC keeps its incremented value.
                        if (Halt) begin
                            r_state <= ST_HALTED;
                        end else begin
                            if (LoadPC) r_pc <= PCIn;
                            r_state <= w_continue ? ST_FETCH : ST_IDLE;
                        end
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // PC is stable through FETCH and WAIT, so it can drive the ROM address directly.
    assign RomAddress        = r_pc;
    assign RomClken          = rom_active(r_state);
    assign IR                = r_ir;
    assign ExecStart         = (r_state == ST_EXEC) && r_exec_first;
    assign TimeStep          = r_state;
    assign OperationFinished = (r_state == ST_HALTED);
    assign PC                = r_pc;
    assign InstrCount        = r_count;

endmodule
